ft245_bus_bridge: RTL and testbench

Sequential bridge between the 68000 bus glue decoder and the FT245-style USB FIFO chip. It runs the serial device window (serial in, serial out, serial status, LED register): it paces the FIFO `_rd` and `wr` strobes, latches FIFO read data, and generates `_dtack` only when the transfer has really completed. It replaces the fixed combinational `_rd`/`wr` assignments in the top-level glue logic and sits directly downstream of the address decode.

---
 rtl/ft245_bus_bridge.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_ft245_bus_bridge.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_bus_bridge.sv
// ft245_bus_bridge: paces the FT245 FIFO strobes for the 68000 serial device window
// and acknowledges the CPU only after the FIFO transfer has actually completed.
module ft245_bus_bridge #(
    parameter int RD_PULSE = 4,
    parameter int WR_PULSE = 4,
    parameter int TIMEOUT  = 4095
) (
    input  logic       clk,
    input  logic       _rst,
    input  logic       sel,
    input  logic       _as,
    input  logic       _ds,
    input  logic       rw,
    input  logic [1:0] addr,
    input  logic [7:0] d_in,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       _dtack,
    input  logic       _rdf,
    input  logic       _txe,
    output logic       _rd,
    output logic       wr,
    input  logic [7:0] f_in,
    output logic [7:0] f_out,
    output logic       f_oe,
    output logic       status_led
);

    localparam int WCW  = $clog2(TIMEOUT + 1);
    localparam int PMAX = (RD_PULSE > WR_PULSE) ? RD_PULSE : WR_PULSE;
    localparam int PCW  = $clog2(PMAX + 1);

    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [PCW-1:0] RD_LAST   = PCW'(RD_PULSE - 1);
    localparam logic [PCW-1:0] WR_HOLD   = PCW'(WR_PULSE);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_STB  = 3'd2,
        ST_WR_WAIT = 3'd3,
        ST_WR_STB  = 3'd4,
        ST_ACK     = 3'd5
    } state_t;

    function automatic logic [7:0] status_byte(input logic err, input logic txe, input logic rdf);
        status_byte = {err, 5'b00000, ~txe, ~rdf};
    endfunction

    logic [1:0]     rdf_sync_r;
    logic [1:0]     txe_sync_r;
    logic           rdf_s;
    logic           txe_s;

    logic           go_s;
    logic           go_r;
    logic           go_d_r;
    logic           as_seen_r;
    logic           start_r;
    logic           edge_s;

    state_t         state_r;
    state_t         state_nx_s;
    logic [PCW-1:0] pcnt_r;
    logic [PCW-1:0] pcnt_nx_s;
    logic [WCW-1:0] wcnt_r;
    logic [WCW-1:0] wcnt_nx_s;
    logic           abort_r;
    logic           abort_nx_s;
    logic           stat_rd_r;
    logic           stat_rd_nx_s;

    logic [7:0]     ack_data_s;
    logic           led_wr_s;
    logic           err_set_s;
    logic           err_clr_s;
    logic           fout_ld_s;

    logic           err_r;
    logic           led_r;
    logic [7:0]     f_out_r;

    logic           rd_n_r;
    logic           wr_r;
    logic           f_oe_r;
    logic           dtack_n_r;
    logic           d_oe_r;
    logic [7:0]     d_out_r;

    assign rdf_s  = rdf_sync_r[1];
    assign txe_s  = txe_sync_r[1];
    assign go_s   = sel & ~_as & ~_ds;
    assign edge_s = go_r & ~go_d_r & as_seen_r;

    // Two-flop synchronizers for the asynchronous FIFO flags (idle high)
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            rdf_sync_r <= 2'b11;
            txe_sync_r <= 2'b11;
        end else begin
            rdf_sync_r <= {rdf_sync_r[0], _rdf};
            txe_sync_r <= {txe_sync_r[0], _txe};
        end
    end

    // Bus cycle start detection; a start stays pending until IDLE consumes it or _as drops
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            go_r      <= 1'b0;
            go_d_r    <= 1'b0;
            as_seen_r <= 1'b1;
            start_r   <= 1'b0;
        end else begin
            go_r   <= go_s;
            go_d_r <= go_r;
            if (_as) begin
                as_seen_r <= 1'b1;
            end else if (edge_s) begin
                as_seen_r <= 1'b0;
            end else begin
                as_seen_r <= as_seen_r;
            end
            if (_as) begin
                start_r <= 1'b0;
            end else if (edge_s) begin
                start_r <= 1'b1;
            end else if (state_r == ST_IDLE) begin
                start_r <= 1'b0;
            end else begin
                start_r <= start_r;
            end
        end
    end

    // FSM state and per-state counters
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_r   <= ST_IDLE;
            pcnt_r    <= '0;
            wcnt_r    <= '0;
            abort_r   <= 1'b0;
            stat_rd_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            pcnt_r    <= pcnt_nx_s;
            wcnt_r    <= wcnt_nx_s;
            abort_r   <= abort_nx_s;
            stat_rd_r <= stat_rd_nx_s;
        end
    end

    // Next-state logic and the side effects attached to each transition
    always_comb begin
        state_nx_s   = state_r;
        pcnt_nx_s    = pcnt_r;
        wcnt_nx_s    = wcnt_r;
        abort_nx_s   = 1'b0;
        stat_rd_nx_s = 1'b0;
        ack_data_s   = 8'h00;
        led_wr_s     = 1'b0;
        err_set_s    = 1'b0;
        err_clr_s    = 1'b0;
        fout_ld_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_r) begin
                    case ({addr, rw})
                        3'b001: begin
                            state_nx_s = ST_RD_WAIT;
                            wcnt_nx_s  = '0;
                        end
                        3'b010: begin
                            state_nx_s = ST_WR_WAIT;
                            wcnt_nx_s  = '0;
                            fout_ld_s  = 1'b1;
                        end
                        3'b101: begin
                            state_nx_s   = ST_ACK;
                            ack_data_s   = status_byte(err_r, txe_s, rdf_s);
                            stat_rd_nx_s = 1'b1;
                        end
                        3'b111: begin
                            state_nx_s = ST_ACK;
                            ack_data_s = {7'b0000000, led_r};
                        end
                        3'b110: begin
                            state_nx_s = ST_ACK;
                            led_wr_s   = 1'b1;
                        end
                        default: begin
                            // status write and mismatched serial direction: ack only
                            state_nx_s = ST_ACK;
                        end
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (_as) begin
                    state_nx_s = ST_IDLE;
                end else if (!rdf_s) begin
                    state_nx_s = ST_RD_STB;
                    pcnt_nx_s  = '0;
                end else if (wcnt_r == WAIT_LAST) begin
                    state_nx_s = ST_ACK;
                    wcnt_nx_s  = wcnt_r + WCW'(1);
                    err_set_s  = 1'b1;
                    ack_data_s = 8'hFF;
                end else begin
                    wcnt_nx_s = wcnt_r + WCW'(1);
                end
            end
            ST_RD_STB: begin
                if (pcnt_r == RD_LAST) begin
                    ack_data_s = f_in;
                    state_nx_s = (abort_r | _as) ? ST_IDLE : ST_ACK;
                end else begin
                    abort_nx_s = abort_r | _as;
                    pcnt_nx_s  = pcnt_r + PCW'(1);
                end
            end
            ST_WR_WAIT: begin
                if (_as) begin
                    state_nx_s = ST_IDLE;
                end else if (!txe_s) begin
                    state_nx_s = ST_WR_STB;
                    pcnt_nx_s  = '0;
                end else if (wcnt_r == WAIT_LAST) begin
                    state_nx_s = ST_ACK;
                    wcnt_nx_s  = wcnt_r + WCW'(1);
                    err_set_s  = 1'b1;
                end else begin
                    wcnt_nx_s = wcnt_r + WCW'(1);
                end
            end
            ST_WR_STB: begin
                // the last count is the data hold cycle after wr falls
                if (pcnt_r == WR_HOLD) begin
                    state_nx_s = (abort_r | _as) ? ST_IDLE : ST_ACK;
                end else begin
                    abort_nx_s = abort_r | _as;
                    pcnt_nx_s  = pcnt_r + PCW'(1);
                end
            end
            ST_ACK: begin
                ack_data_s = d_out_r;
                if (_as) begin
                    state_nx_s = ST_IDLE;
                    err_clr_s  = stat_rd_r;
                end else begin
                    state_nx_s   = ST_ACK;
                    stat_rd_nx_s = stat_rd_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Sticky error flag, LED register and FIFO write data latch
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            err_r   <= 1'b0;
            led_r   <= 1'b0;
            f_out_r <= 8'h00;
        end else begin
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (err_clr_s) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
            if (led_wr_s) begin
                led_r <= d_in[0];
            end else begin
                led_r <= led_r;
            end
            if (fout_ld_s) begin
                f_out_r <= d_in;
            end else begin
                f_out_r <= f_out_r;
            end
        end
    end

    // Registered bus and FIFO outputs, decoded from the next state
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            rd_n_r    <= 1'b1;
            wr_r      <= 1'b0;
            f_oe_r    <= 1'b0;
            dtack_n_r <= 1'b1;
            d_oe_r    <= 1'b0;
            d_out_r   <= 8'h00;
        end else begin
            rd_n_r    <= (state_nx_s != ST_RD_STB);
            wr_r      <= (state_nx_s == ST_WR_STB) && (pcnt_nx_s < WR_HOLD);
            f_oe_r    <= (state_nx_s == ST_WR_STB);
            dtack_n_r <= (state_nx_s != ST_ACK);
            d_oe_r    <= (state_nx_s == ST_ACK) && rw;
            d_out_r   <= (state_nx_s == ST_ACK) ? ack_data_s : 8'h00;
        end
    end

    assign _rd        = rd_n_r;
    assign wr         = wr_r;
    assign f_oe       = f_oe_r;
    assign f_out      = f_out_r;
    assign _dtack     = dtack_n_r;
    assign d_oe       = d_oe_r;
    assign d_out      = d_out_r;
    assign status_led = led_r;

endmodule

// File: tb/tb_ft245_bus_bridge.sv
// Directed bench for ft245_bus_bridge: default-timing instance plus a TIMEOUT=15
// instance on the same bus for the wait-timeout scenario.
module tb_ft245_bus_bridge;

    logic       clk = 1'b0;
    logic       _rst;
    logic       sel;
    logic       _as;
    logic       _ds;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] d_in;
    logic       _rdf;
    logic       _txe;
    logic [7:0] f_in;

    logic [7:0] d_out,   t_d_out;
    logic       d_oe,    t_d_oe;
    logic       _dtack,  t_dtack;
    logic       _rd,     t_rd;
    logic       wr,      t_wr;
    logic [7:0] f_out,   t_f_out;
    logic       f_oe,    t_f_oe;
    logic       status_led, t_status_led;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ft245_bus_bridge dut (
        .clk(clk), ._rst(_rst), .sel(sel), ._as(_as), ._ds(_ds), .rw(rw),
        .addr(addr), .d_in(d_in), .d_out(d_out), .d_oe(d_oe), ._dtack(_dtack),
        ._rdf(_rdf), ._txe(_txe), ._rd(_rd), .wr(wr), .f_in(f_in),
        .f_out(f_out), .f_oe(f_oe), .status_led(status_led)
    );

    ft245_bus_bridge #(.RD_PULSE(4), .WR_PULSE(4), .TIMEOUT(15)) dut_to (
        .clk(clk), ._rst(_rst), .sel(sel), ._as(_as), ._ds(_ds), .rw(rw),
        .addr(addr), .d_in(d_in), .d_out(t_d_out), .d_oe(t_d_oe), ._dtack(t_dtack),
        ._rdf(_rdf), ._txe(_txe), ._rd(t_rd), .wr(t_wr), .f_in(f_in),
        .f_out(t_f_out), .f_oe(t_f_oe), .status_led(t_status_led)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        sel = 1'b0;
        _as = 1'b1;
        _ds = 1'b1;
    endtask

    task automatic start_cycle(input logic [1:0] a, input logic r, input logic [7:0] d);
        addr = a;
        rw   = r;
        d_in = d;
        sel  = 1'b1;
        _as  = 1'b0;
        _ds  = 1'b0;
    endtask

    // lat = cycles from the edge sampling go to the first low _dtack, -1 if none
    task automatic bus_cycle(input logic [1:0] a, input logic r, input logic [7:0] d,
                             input logic use_t, output logic [7:0] data,
                             output int lat, output logic dt_after);
        logic dt;
        start_cycle(a, r, d);
        lat  = -1;
        data = 8'h00;
        for (int k = 0; k < 40; k++) begin
            cyc();
            dt = use_t ? t_dtack : _dtack;
            if (dt === 1'b0) begin
                lat = k;
                break;
            end
        end
        data = use_t ? t_d_out : d_out;
        idle_bus();
        cyc();
        dt_after = use_t ? t_dtack : _dtack;
        cyc();
    endtask

    task automatic test_reset();
        _rst = 1'b0;
        idle_bus();
        rw = 1'b1; addr = 2'b00; d_in = 8'h00; f_in = 8'h00;
        _rdf = 1'b1; _txe = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({_rd, wr, _dtack, d_oe, f_oe, status_led, d_out, f_out} !== {6'b101000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_in: outputs=%b %h %h", {_rd, wr, _dtack, d_oe, f_oe, status_led}, d_out, f_out);
        end
        _rst = 1'b1;
        repeat (3) cyc();
        checks++;
        if ({_rd, wr, _dtack, d_oe, f_oe, status_led, d_out, f_out} !== {6'b101000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_after: outputs=%b %h %h", {_rd, wr, _dtack, d_oe, f_oe, status_led}, d_out, f_out);
        end
    endtask

    task automatic test_serial_read();
        int   rd_low = 0;
        int   first  = -1;
        logic bad_rd = 1'b0;
        _rdf = 1'b0; f_in = 8'h5A;
        repeat (3) cyc();
        start_cycle(2'b00, 1'b1, 8'h00);
        cyc();
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (_rd === 1'b0) rd_low++;
            if (_rd === 1'b0 && (k < 3 || k > 6)) bad_rd = 1'b1;
            if (_dtack === 1'b0 && first < 0) first = k;
        end
        checks++;
        if (rd_low != 4) begin errors++; $display("FAIL rd_width: got %0d want 4", rd_low); end
        checks++;
        if (bad_rd) begin errors++; $display("FAIL rd_window: _rd low outside cycles 3..6"); end
        checks++;
        if (first != 7) begin errors++; $display("FAIL rd_latency: got %0d want 7", first); end
        checks++;
        if (d_out !== 8'h5A || d_oe !== 1'b1) begin
            errors++; $display("FAIL rd_data: got %h oe=%b want 5a oe=1", d_out, d_oe);
        end
        idle_bus();
        cyc();
        checks++;
        if (_dtack !== 1'b1 || d_oe !== 1'b0) begin
            errors++; $display("FAIL rd_release: dtack=%b oe=%b want 1 0", _dtack, d_oe);
        end
        cyc();
    endtask

    task automatic test_timeout();
        int         first = -1;
        logic       rd_pulsed = 1'b0;
        logic [7:0] data;
        int         lat;
        logic       dta;
        _rdf = 1'b1; _txe = 1'b1;
        repeat (3) cyc();
        start_cycle(2'b00, 1'b1, 8'h00);
        cyc();
        for (int k = 1; k <= 18; k++) begin
            cyc();
            if (t_rd === 1'b0) rd_pulsed = 1'b1;
            if (t_dtack === 1'b0 && first < 0) first = k;
        end
        checks++;
        if (first != 17) begin errors++; $display("FAIL to_latency: got %0d want 17", first); end
        checks++;
        if (rd_pulsed) begin errors++; $display("FAIL to_no_rd: _rd pulsed during timeout"); end
        checks++;
        if (t_d_out !== 8'hFF) begin errors++; $display("FAIL to_data: got %h want ff", t_d_out); end
        idle_bus();
        repeat (2) cyc();
        bus_cycle(2'b10, 1'b1, 8'h00, 1'b1, data, lat, dta);
        checks++;
        if (data !== 8'h80 || lat != 2) begin
            errors++; $display("FAIL to_err_set: got %h lat %0d want 80 lat 2", data, lat);
        end
        bus_cycle(2'b10, 1'b1, 8'h00, 1'b1, data, lat, dta);
        checks++;
        if (data !== 8'h00 || dta !== 1'b1) begin
            errors++; $display("FAIL to_err_clr: got %h dtack_after=%b want 00 1", data, dta);
        end
    endtask

    task automatic test_serial_write();
        logic       wr_early = 1'b0;
        logic       fout_bad = 1'b0;
        logic [7:0] wr_v, foe_v, dt_v;
        _txe = 1'b1;
        repeat (3) cyc();
        start_cycle(2'b01, 1'b0, 8'hC3);
        cyc();
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (wr !== 1'b0 || f_oe !== 1'b0) wr_early = 1'b1;
        end
        checks++;
        if (wr_early) begin errors++; $display("FAIL wr_blocked: wr/f_oe active while _txe high"); end
        _txe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            wr_v[i]  = wr;
            foe_v[i] = f_oe;
            dt_v[i]  = _dtack;
            if (wr === 1'b1 && f_out !== 8'hC3) fout_bad = 1'b1;
        end
        checks++;
        if (wr_v !== 8'b0011_1100) begin errors++; $display("FAIL wr_pulse: got %b want 00111100", wr_v); end
        checks++;
        if (foe_v !== 8'b0111_1100) begin errors++; $display("FAIL wr_foe: got %b want 01111100", foe_v); end
        checks++;
        if (dt_v !== 8'b0111_1111) begin errors++; $display("FAIL wr_dtack: got %b want 01111111", dt_v); end
        checks++;
        if (fout_bad) begin errors++; $display("FAIL wr_fout: f_out not c3 during wr"); end
        idle_bus();
        cyc();
        checks++;
        if (_dtack !== 1'b1) begin errors++; $display("FAIL wr_release: dtack=%b want 1", _dtack); end
        cyc();
    endtask

    task automatic test_led_status();
        logic [7:0] data;
        int         lat;
        logic       dta;
        _txe = 1'b0; _rdf = 1'b1;
        repeat (3) cyc();
        bus_cycle(2'b11, 1'b0, 8'h01, 1'b0, data, lat, dta);
        checks++;
        if (lat != 2 || status_led !== 1'b1) begin
            errors++; $display("FAIL led_write: lat %0d led %b want 2 1", lat, status_led);
        end
        bus_cycle(2'b11, 1'b1, 8'h00, 1'b0, data, lat, dta);
        checks++;
        if (data !== 8'h01 || lat != 2) begin
            errors++; $display("FAIL led_read: got %h lat %0d want 01 lat 2", data, lat);
        end
        bus_cycle(2'b10, 1'b1, 8'h00, 1'b0, data, lat, dta);
        checks++;
        if (data !== 8'h02 || lat != 2 || dta !== 1'b1) begin
            errors++; $display("FAIL status_read: got %h lat %0d dt %b want 02 2 1", data, lat, dta);
        end
        bus_cycle(2'b11, 1'b0, 8'hFE, 1'b0, data, lat, dta);
        checks++;
        if (status_led !== 1'b0) begin errors++; $display("FAIL led_bit0: led %b want 0", status_led); end
        bus_cycle(2'b01, 1'b1, 8'h00, 1'b0, data, lat, dta);
        checks++;
        if (data !== 8'h00 || lat != 2) begin
            errors++; $display("FAIL unmapped_read: got %h lat %0d want 00 lat 2", data, lat);
        end
    endtask

    task automatic test_abort();
        int         rd_low = 0;
        logic       dt_seen = 1'b0;
        logic [7:0] data;
        int         lat;
        logic       dta;
        _rdf = 1'b0; _txe = 1'b0; f_in = 8'h33;
        repeat (3) cyc();
        start_cycle(2'b00, 1'b1, 8'h00);
        cyc();
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (_rd === 1'b0) rd_low++;
            if (_dtack === 1'b0) dt_seen = 1'b1;
            if (k == 4) idle_bus();
        end
        checks++;
        if (rd_low != 4) begin errors++; $display("FAIL abort_rd_width: got %0d want 4", rd_low); end
        checks++;
        if (dt_seen) begin errors++; $display("FAIL abort_dtack: _dtack asserted on aborted cycle"); end
        bus_cycle(2'b10, 1'b1, 8'h00, 1'b0, data, lat, dta);
        checks++;
        if (data !== 8'h03 || lat != 2) begin
            errors++; $display("FAIL abort_recover: got %h lat %0d want 03 lat 2", data, lat);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] data;
        int         lat;
        logic       dta;
        _txe = 1'b0; _rdf = 1'b0;
        repeat (3) cyc();
        start_cycle(2'b01, 1'b0, 8'hAA);
        cyc();
        repeat (4) cyc();
        checks++;
        if (wr !== 1'b1 || f_oe !== 1'b1) begin
            errors++; $display("FAIL rst_pre: wr=%b f_oe=%b want 1 1", wr, f_oe);
        end
        #2;
        _rst = 1'b0;
        #1;
        checks++;
        if ({wr, f_oe, _dtack, f_out} !== {3'b001, 8'h00}) begin
            errors++; $display("FAIL rst_async: wr=%b f_oe=%b dtack=%b f_out=%h want 0 0 1 00", wr, f_oe, _dtack, f_out);
        end
        idle_bus();
        repeat (2) cyc();
        _rst = 1'b1;
        repeat (3) cyc();
        bus_cycle(2'b10, 1'b1, 8'h00, 1'b0, data, lat, dta);
        checks++;
        if (data !== 8'h03 || lat != 2 || dta !== 1'b1) begin
            errors++; $display("FAIL rst_recover: got %h lat %0d dt %b want 03 2 1", data, lat, dta);
        end
    endtask

    initial begin
        test_reset();
        test_serial_read();
        test_timeout();
        test_serial_write();
        test_led_status();
        test_abort();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
